// File: rtl/kb_key_sched.sv
// kb_key_sched: captures released-key codes from the PS/2 code path into a small FIFO and
// hands them to two consumers round-robin. Optional repeat filter: KB_SCHED_REPEAT_FILTER_EN.
module kb_key_sched #(
    parameter int unsigned DEPTH_LOG2  = 2,
    parameter int unsigned HOLDOFF_CYC = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                kb_listo,
    input  logic [7:0]          kb_key_code,
    output logic                kb_var,
    input  logic                req0,
    input  logic                req1,
    output logic                gnt0,
    output logic                gnt1,
    output logic [7:0]          key_out,
    output logic [DEPTH_LOG2:0] fifo_count,
    output logic                overflow,
    input  logic                ovf_clr
);
    localparam int unsigned         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);

    // The repeat-filter counter is 16 bits wide; larger windows cannot be represented.
    if (HOLDOFF_CYC > 65535) begin : g_holdoff_range
        $error("HOLDOFF_CYC must fit in 16 bits");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT_LOW
    } cap_state_e;

    cap_state_e            state_q;
    logic                  kb_var_q;
    logic                  gnt0_q;
    logic                  gnt1_q;
    logic                  overflow_q;
    logic                  rr_q;
    logic [7:0]            key_out_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [7:0]            mem_q [DEPTH];

    logic pop;
    logic pop_side;
    logic push_req;
    logic has_room;
    logic repeat_drop;
    logic push_ok;
    logic push_drop;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pop       = (count_q != '0) && (req0 || req1);
        // A lone requester always wins; with both high, rr_q picks the side (0 = req0).
        pop_side  = req1 && (!req0 || rr_q);
        push_req  = (state_q == ST_IDLE) && kb_listo;
        has_room  = (count_q < DEPTH_CNT) || pop;
        push_ok   = push_req && !repeat_drop && has_room;
        push_drop = push_req && !repeat_drop && !has_room;
        count_d   = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

`ifdef KB_SCHED_REPEAT_FILTER_EN
    localparam logic [15:0] HOLDOFF = 16'(HOLDOFF_CYC);

    logic [7:0]  last_code_q;
    logic [15:0] hold_cnt_q;
    logic [15:0] hold_cnt_d;

    assign repeat_drop = (kb_key_code == last_code_q) && (hold_cnt_q < HOLDOFF);

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (push_ok) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q < HOLDOFF) begin
            hold_cnt_d = hold_cnt_q + 16'd1;
        end
    end

    // Reset leaves the window already expired so the very first code is never filtered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_code_q <= 8'h00;
            hold_cnt_q  <= HOLDOFF;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            if (push_ok) begin
                last_code_q <= kb_key_code;
            end
        end
    end
`else
    assign repeat_drop = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            kb_var_q   <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            key_out_q  <= 8'h00;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rr_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            kb_var_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (kb_listo) begin
                        state_q  <= ST_ACK;
                        kb_var_q <= 1'b1;
                    end
                end
                ST_ACK:      state_q <= ST_WAIT_LOW;
                ST_WAIT_LOW: begin
                    if (!kb_listo) begin
                        state_q <= ST_IDLE;
                    end
                end
                default:     state_q <= ST_IDLE;
            endcase

            gnt0_q <= pop && !pop_side;
            gnt1_q <= pop && pop_side;
            if (pop) begin
                key_out_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                rr_q      <= !pop_side;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            count_q    <= count_d;
            overflow_q <= push_drop || (overflow_q && !ovf_clr);
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= kb_key_code;
        end
    end

    assign kb_var     = kb_var_q;
    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign key_out    = key_out_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule
